// File: rtl/ws2812_frame_tx.sv
// ws2812_frame_tx
//   Serializes a latched frame of NUM_LEDS 24-bit colours into the WS2812
//   single-wire bitstream, then holds the line low for the latch interval.
//
// Ports
//   clk    in   system clock
//   rst    in   synchronous, active-high reset
//   start  in   one-cycle transmit request (honoured only when idle)
//   frame  in   NUM_LEDS*24 colours; LED k at [24k+23:24k] as {R,G,B}
//   busy   out  high from the cycle after an accepted start until done
//   done   out  one-cycle pulse when the latch interval ends
//   ws     out  WS2812 data line, registered
module ws2812_frame_tx #(
  parameter int NUM_LEDS  = 7,
  parameter int BIT_CYC   = 15,
  parameter int T0H_CYC   = 4,
  parameter int T1H_CYC   = 9,
  parameter int RESET_CYC = 960
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_LEDS*24-1:0]  frame,
  output logic                    busy,
  output logic                    done,
  output logic                    ws
);

  localparam int CYC_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int LAT_W = $clog2(RESET_CYC + 1);
  localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CYC_W-1:0] BIT_LAST = CYC_W'(BIT_CYC - 1);
  localparam logic [CYC_W-1:0] T0H      = CYC_W'(T0H_CYC);
  localparam logic [CYC_W-1:0] T1H      = CYC_W'(T1H_CYC);
  localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(RESET_CYC);
  localparam logic [LED_W-1:0] LED_LAST = LED_W'(NUM_LEDS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  logic [1:0]              state;
  logic [CYC_W-1:0]        cyc;
  logic [4:0]              bit_idx;
  logic [LED_W-1:0]        led_idx;
  logic [LAT_W-1:0]        lat_cnt;
  logic [NUM_LEDS*24-1:0]  shadow;
  logic [NUM_LEDS*24-1:0]  grb_frame;
  logic [23:0]             cur_word;
  logic                    cur_bit;
  logic [CYC_W-1:0]        high_cyc;
  logic                    accept;
  logic                    led_end;

  // Reorder each {R,G,B} word into wire order {G,R,B} so the shadow can be
  // sent MSB first straight out of the low 24 bits.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grb_frame = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      grb_frame[24*k +: 24] = {frame[24*k+8 +: 8], frame[24*k+16 +: 8], frame[24*k +: 8]};
    end
  end

  // The LED being sent always sits in the low word; the shadow shifts down
  // by one LED at each LED boundary.
  assign cur_word = shadow[23:0];
  assign cur_bit  = cur_word[bit_idx];
  assign high_cyc = cur_bit ? T1H : T0H;

  // A start seen while done is still high belongs to the finishing frame
  // and is dropped; the next cycle is the earliest accepted restart.
  assign accept  = (state == IDLE) && start && !done;
  assign led_end = (state == SEND) && (cyc == BIT_LAST) && (bit_idx == 5'd0);

  // NOTE: the frame shadow is pure datapath and is fully overwritten on every
  // accepted start, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      shadow <= grb_frame;
    end else if (led_end) begin
      shadow <= shadow >> 24;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ws      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cyc     <= '0;
      bit_idx <= '0;
      led_idx <= '0;
      lat_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ws   <= 1'b0;
          busy <= 1'b0;
          if (accept) begin
            state   <= SEND;
            cyc     <= '0;
            bit_idx <= 5'd23;
            led_idx <= '0;
          end
        end

        SEND: begin
          busy <= 1'b1;
          ws   <= (cyc < high_cyc);
          if (cyc == BIT_LAST) begin
            cyc <= '0;
            if (bit_idx == 5'd0) begin
              bit_idx <= 5'd23;
              if (led_idx == LED_LAST) begin
                state   <= LATCH;
                lat_cnt <= '0;
              end else begin
                led_idx <= led_idx + 1'b1;
              end
            end else begin
              bit_idx <= bit_idx - 1'b1;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end

        LATCH: begin
          ws <= 1'b0;
          // lat_cnt 0..RESET_CYC-1 are the low cycles; the RESET_CYC edge
          // raises done and drops busy together.
          if (lat_cnt == LAT_END) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          ws    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ws2812_frame_tx.md
# ws2812_frame_tx

Serializes a latched frame of NUM_LEDS 24-bit colours into the single-wire WS2812 bitstream that drives the ear LED chain. It sits directly downstream of the per-ear colour logic, whose rgb0..rgb6 words arrive flattened on `frame`, and owns the `ws` pin. The block sends one frame per `start`, then holds the line low for the latch/reset interval.

## Interface
- NUM_LEDS, 7: LEDs in the chain.
- BIT_CYC, 15: clock cycles per bit period; 1.25 µs at 12 MHz.
- T0H_CYC, 4: high time for a 0 bit, in cycles.
- T1H_CYC, 9: high time for a 1 bit, in cycles.
- RESET_CYC, 960: low latch time after the last bit; 80 µs at 12 MHz.
- Legal ranges: T0H_CYC < T1H_CYC < BIT_CYC; RESET_CYC ≥ 1.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to transmit `frame`.
- frame  in  NUM_LEDS*24  colours; LED k at bits [24k+23:24k], each formatted {R[7:0], G[7:0], B[7:0]}.
- busy  out  1  high from the cycle after an accepted start until `done`.
- done  out  1  one-cycle pulse when the latch interval ends.
- ws  out  1  WS2812 data line, registered.

## Operation
- Clock is `clk`. Reset is synchronous and active-high on `rst`.
- Reset values: ws=0, busy=0, done=0, state=IDLE, all counters 0.
- States and transitions:
  - IDLE: start=1 moves to SEND. In that cycle `frame` is copied into an internal shadow register, led index=0, bit index=23, and the bit cycle counter=0.
  - SEND: transmits bits. When the last bit of LED NUM_LEDS-1 completes, moves to LATCH.
  - LATCH: ws=0 for RESET_CYC cycles, then pulses done=1 for one cycle and returns to IDLE.
- Wire order per LED is G[7:0], R[7:0], B[7:0], each MSB first. LEDs go out in the order 0, 1, …, NUM_LEDS-1.
- Bit encoding, with cycle counter c = 0..BIT_CYC-1 inside a bit:
  - ws=1 while c < (bit ? T1H_CYC : T0H_CYC), else ws=0.
  - Bits go back to back with no gap between bits or between LEDs.
- `start` while busy is ignored. No queuing, and the shadow register is not modified.
- `frame` may change freely after the accepting cycle. Only the shadow register is transmitted.
- Counters:
  - bit cycle counter ≥ clog2(BIT_CYC) bits, wraps to 0 at BIT_CYC-1.
  - latch counter ≥ clog2(RESET_CYC+1) bits.
  - LED index ≥ clog2(NUM_LEDS) bits.
  - No counter may overflow at the maximum parameter values.
- Reset mid-frame: on the next edge ws=0, busy=0, state=IDLE, and done is not asserted. The aborted frame is never resumed.
- If `start` and `done` occur in the same cycle: done is asserted in the final LATCH cycle and start is ignored. Start is accepted from the following cycle (IDLE).

## Timing
- start sampled high at edge N in IDLE. busy=1 and ws=1 (first bit's high phase) from edge N+1.
- The first bit's high phase lasts exactly T0H_CYC or T1H_CYC cycles.
- Each bit occupies exactly BIT_CYC cycles of ws.
- SEND duration = NUM_LEDS*24*BIT_CYC cycles.
- LATCH duration = RESET_CYC cycles with ws=0.
- done=1 in the cycle after the last LATCH cycle.
- busy falls in the same cycle done rises.
- Frame period, from start to done rising = NUM_LEDS*24*BIT_CYC + RESET_CYC + 1 cycles. This is 3481 cycles at the defaults.
- Earliest back-to-back start: the cycle after done.

## Test plan
- Reset: hold rst 3 cycles, then idle 20 cycles. Required: ws=0, busy=0, done=0 throughout.
- Single frame, defaults, frame word 0 = {8'h00,8'h80,8'h00}, all others 0.
  - Measured high times: first bit (G7=1) high 9 cycles/low 6; the next 23 bits of LED 0 high 4/low 11; all remaining LEDs all-zero bits.
  - done fires exactly 3481 cycles after start.
- Byte order: LED 0 = {8'h0B,8'h40,8'h90}.
  - Decoded wire bits for LED 0 = 24'h400B90 (GRB), MSB first.
  - Bench decodes ws by high-time threshold at 6 cycles.
- Ignored restart: pulse start again mid-SEND with a different frame. Required: stream unchanged, exactly one done, no second frame.
- Reset mid-frame: assert rst during LED 3, bit 10. Required: ws=0 and busy=0 next cycle, and no done. A new start after release produces a complete correct frame.
- Parameter sweep: NUM_LEDS=1, BIT_CYC=5, T0H_CYC=1, T1H_CYC=3, RESET_CYC=1. Required: frame period 122 cycles, and start asserted on the done cycle is ignored.
